mult_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage, the next generation of the fixed 32-bit HI/LO arithmetic block. It adds configurable operand width and multiplier pipeline depth, an explicit start/busy/done handshake, a flush input for pipeline squash, and divide-by-zero reporting. It accepts one operation at a time and holds the 2×WIDTH result stable until the next accepted start, so the EX stage can stall on `busy`.

---
 rtl/mult_div_if.sv | 26 ++
 rtl/mult_div_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [2:0]           op;
   logic                 flush;
   logic [WIDTH-1:0]     operand_1;
   logic [WIDTH-1:0]     operand_2;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;
   logic                 busy;
   logic                 done;
   logic                 div_zero;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, op, flush, operand_1, operand_2, hi, lo,
      input  busy, done, div_zero, result
   );

   modport slave (
      input  start, op, flush, operand_1, operand_2, hi, lo,
      output busy, done, div_zero, result
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply / multiply-accumulate / restoring divide unit with
// start/busy/done handshake, flush and divide-by-zero reporting.
// result is {hi, lo}: product/accumulation, or {remainder, quotient}.
module mult_div_unit #(
   parameter int WIDTH        = 32,
   parameter int MULT_LATENCY = 2
) (
   input logic       clk,
   input logic       rst,
   mult_div_if.slave bus
);

   localparam int W       = WIDTH;
   localparam int W2      = 2 * WIDTH;
   localparam int CNT_MAX = (WIDTH > MULT_LATENCY) ? WIDTH : MULT_LATENCY;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   // Two's-complement negate when n is set (operand / quotient / remainder width).
   function automatic logic [W-1:0] cneg_w(input logic n, input logic [W-1:0] v);
      return n ? W'(-v) : v;
   endfunction

   // Two's-complement negate when n is set (full product width).
   function automatic logic [W2-1:0] cneg_2w(input logic n, input logic [W2-1:0] v);
      return n ? W2'(-v) : v;
   endfunction

   // Control state (reset)
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            dz_q, dz_d;
   logic [W2-1:0]   result_q, result_d;

   // Operation context and divider datapath (no reset needed)
   logic [2:0]      op_q, op_d;
   logic [W-1:0]    op1_q, op1_d;
   logic [W-1:0]    mag1_q, mag1_d;
   logic [W-1:0]    mag2_q, mag2_d;
   logic            neg1_q, neg1_d;
   logic            neg2_q, neg2_d;
   logic            divz_q, divz_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;

   // Accept-path sign handling: signed ops are the even op codes.
   logic            in_signed, in_neg1, in_neg2, in_is_div;
   logic [W-1:0]    in_mag1, in_mag2;

   assign in_signed = ~bus.op[0];
   assign in_is_div = bus.op[2] & bus.op[1];
   assign in_neg1   = in_signed & bus.operand_1[W-1];
   assign in_neg2   = in_signed & bus.operand_2[W-1];
   assign in_mag1   = cneg_w(in_neg1, bus.operand_1);
   assign in_mag2   = cneg_w(in_neg2, bus.operand_2);

   // Multiply path: magnitude product, re-signed, then optional accumulate.
   logic [W2-1:0]   mag_prod, sprod, mul_res;

   assign mag_prod = W2'(mag1_q) * W2'(mag2_q);
   assign sprod    = cneg_2w(neg1_q ^ neg2_q, mag_prod);
   assign mul_res  = (op_q[2:1] == 2'b01) ? acc_q + sprod :
                     (op_q[2:1] == 2'b10) ? acc_q - sprod : sprod;

   // Restoring divide step: shift next dividend bit into the partial remainder
   // and try subtracting the divisor; bit W of the trial is the borrow.
   logic [W:0]      shifted, trial;
   logic [W2-1:0]   div_res;

   assign shifted = {rem_q, quo_q[W-1]};
   assign trial   = shifted - {1'b0, mag2_q};
   assign div_res = {cneg_w(neg1_q, rem_q), cneg_w(neg1_q ^ neg2_q, quo_q)};

   // Next-state and datapath update logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      dz_d     = dz_q;
      result_d = result_q;
      op_d     = op_q;
      op1_d    = op1_q;
      mag1_d   = mag1_q;
      mag2_d   = mag2_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      divz_d   = divz_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      quo_d    = quo_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               op_d   = bus.op;
               op1_d  = bus.operand_1;
               mag1_d = in_mag1;
               mag2_d = in_mag2;
               neg1_d = in_neg1;
               neg2_d = in_neg2;
               acc_d  = {bus.hi, bus.lo};
               dz_d   = 1'b0;
               divz_d = 1'b0;
               if (in_is_div) begin
                  rem_d = '0;
                  quo_d = in_mag1;
                  if (bus.operand_2 == '0) begin
                     divz_d  = 1'b1;
                     state_d = S_FIX;
                  end else begin
                     cnt_d   = CW'(W - 1);
                     state_d = S_DIV;
                  end
               end else begin
                  cnt_d   = CW'(MULT_LATENCY - 1);
                  state_d = S_MUL;
               end
            end
         end

         S_MUL: begin
            if (bus.flush) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               result_d = mul_res;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_DIV: begin
            if (bus.flush) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               if (!trial[W]) begin
                  rem_d = trial[W-1:0];
                  quo_d = {quo_q[W-2:0], 1'b1};
               end else begin
                  rem_d = shifted[W-1:0];
                  quo_d = {quo_q[W-2:0], 1'b0};
               end
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end

         S_FIX: begin
            state_d = S_IDLE;
            if (!bus.flush) begin
               done_d = 1'b1;
               if (divz_q) begin
                  result_d = {op1_q, {W{1'b1}}};
                  dz_d     = 1'b1;
               end else begin
                  result_d = div_res;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Control and visible result registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         result_q <= result_d;
      end
   end

   // Operation context and divider working registers.
   always_ff @(posedge clk) begin
      op_q   <= op_d;
      op1_q  <= op1_d;
      mag1_q <= mag1_d;
      mag2_q <= mag2_d;
      neg1_q <= neg1_d;
      neg2_q <= neg2_d;
      divz_q <= divz_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
   assign bus.result   = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a 32-bit / latency-2 instance and a
// 16-bit / latency-3 instance share clock and reset.
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_div_if #(.WIDTH(32)) ifa ();
   mult_div_if #(.WIDTH(16)) ifb ();

   mult_div_unit #(.WIDTH(32), .MULT_LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   mult_div_unit #(.WIDTH(16), .MULT_LATENCY(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   typedef struct {
      logic [63:0] res;
      logic        dz;
      int          lat;
      int          t0;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Independent reference: wide integer arithmetic on sign-extended values.
   function automatic logic [63:0] model(input int w, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] h, input logic [31:0] l,
                                         output logic dz);
      logic [63:0] m, m2, xa, xb, acc, p, q, r;
      logic        sg;
      m  = (64'd1 << w) - 64'd1;
      m2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
      sg = ~op[0];
      dz = 1'b0;
      xa = {32'd0, a} & m;
      xb = {32'd0, b} & m;
      if (sg && xa[w-1]) xa = xa | ~m;
      if (sg && xb[w-1]) xb = xb | ~m;
      acc = (({32'd0, h} & m) << w) | ({32'd0, l} & m);
      p   = xa * xb;
      case (op)
         3'd0, 3'd1: return p & m2;
         3'd2, 3'd3: return (acc + p) & m2;
         3'd4, 3'd5: return (acc - p) & m2;
         default: begin
            if (({32'd0, b} & m) == 64'd0) begin
               dz = 1'b1;
               return (({32'd0, a} & m) << w) | m;
            end
            if (sg) begin
               q = $signed(xa) / $signed(xb);
               r = $signed(xa) % $signed(xb);
            end else begin
               q = xa / xb;
               r = xa % xb;
            end
            return ((r & m) << w) | (q & m);
         end
      endcase
   endfunction

   // Monitors: pop and compare on every done pulse.
   always @(negedge clk) begin
      if (rst && ifa.done === 1'b1) begin
         if (qa.size() == 0) chk("a_spurious_done", 64'(ifa.done), 64'd0);
         else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_result", ifa.result, e.res);
            chk("a_div_zero", 64'(ifa.div_zero), 64'(e.dz));
            chk("a_latency", 64'(cyc - e.t0 - 1), 64'(e.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (rst && ifb.done === 1'b1) begin
         if (qb.size() == 0) chk("b_spurious_done", 64'(ifb.done), 64'd0);
         else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_result", 64'(ifb.result), e.res);
            chk("b_div_zero", 64'(ifb.div_zero), 64'(e.dz));
            chk("b_latency", 64'(cyc - e.t0 - 1), 64'(e.lat));
         end
      end
   end

   task automatic issue_a(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input bit push,
                          input logic [63:0] exp, input logic dz, input int lat);
      ifa.op = op; ifa.operand_1 = a; ifa.operand_2 = b; ifa.hi = h; ifa.lo = l;
      ifa.start = 1'b1;
      if (push) qa.push_back('{res: exp, dz: dz, lat: lat, t0: cyc});
      @(negedge clk);
      ifa.start = 1'b0;
   endtask

   task automatic issue_b(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l,
                          input logic [63:0] exp, input logic dz, input int lat);
      ifb.op = op; ifb.operand_1 = a[15:0]; ifb.operand_2 = b[15:0];
      ifb.hi = h[15:0]; ifb.lo = l[15:0];
      ifb.start = 1'b1;
      qb.push_back('{res: exp, dz: dz, lat: lat, t0: cyc});
      @(negedge clk);
      ifb.start = 1'b0;
   endtask

   task automatic drain_a(input int max);
      int n = 0;
      while (qa.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("a_drain", 64'(qa.size()), 64'd0);
      qa.delete();
   endtask

   task automatic drain_b(input int max);
      int n = 0;
      while (qb.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("b_drain", 64'(qb.size()), 64'd0);
      qb.delete();
   endtask

   task automatic run_a(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input logic [63:0] exp, input logic dz, input int lat);
      issue_a(op, a, b, h, l, 1'b1, exp, dz, lat);
      drain_a(60);
   endtask

   task automatic run_b(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic dz, input int lat);
      issue_b(op, a, b, 32'd0, 32'd0, exp, dz, lat);
      drain_b(40);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] e64;
      logic        edz;
      int          nd;
      int          n;
      logic [2:0]  rop;
      logic [31:0] ra, rb, rh, rl;

      ifa.start = 0; ifa.flush = 0; ifa.op = 0;
      ifa.operand_1 = 0; ifa.operand_2 = 0; ifa.hi = 0; ifa.lo = 0;
      ifb.start = 0; ifb.flush = 0; ifb.op = 0;
      ifb.operand_1 = 0; ifb.operand_2 = 0; ifb.hi = 0; ifb.lo = 0;

      repeat (2) @(negedge clk);
      chk("rst_result", ifa.result, 64'd0);
      chk("rst_busy", 64'(ifa.busy), 64'd0);
      chk("rst_done", 64'(ifa.done), 64'd0);
      chk("rst_dz", 64'(ifa.div_zero), 64'd0);
      chk("rst_b_result", 64'(ifb.result), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Signed multiply with busy window
      issue_a(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 2);
      chk("mult_busy_c1", 64'(ifa.busy), 64'd1);
      @(negedge clk);
      chk("mult_busy_c2", 64'(ifa.busy), 64'd1);
      @(negedge clk);
      chk("mult_busy_done", 64'(ifa.busy), 64'd0);
      drain_a(10);

      run_a(3'd3, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0, 2);
      run_a(3'd4, 32'd2, 32'd3, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 2);
      run_a(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33);
      run_a(3'd7, 32'hFFFF_FFFF, 32'h10, 0, 0, 64'h0000_000F_0FFF_FFFF, 1'b0, 33);
      run_a(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 64'h0000_0000_8000_0000, 1'b0, 33);

      // Divide by zero, then a multiply clears the flag at acceptance
      run_a(3'd7, 32'h1234, 32'd0, 0, 0, 64'h0000_1234_FFFF_FFFF, 1'b1, 1);
      chk("dz_held", 64'(ifa.div_zero), 64'd1);
      issue_a(3'd0, 32'd7, 32'd6, 0, 0, 1'b1, 64'd42, 1'b0, 2);
      chk("dz_clear", 64'(ifa.div_zero), 64'd0);
      drain_a(10);

      // Back-to-back: second start in the done cycle of the first
      issue_a(3'd1, 32'd3, 32'd4, 0, 0, 1'b1, 64'd12, 1'b0, 2);
      n = 0;
      while (ifa.done !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      issue_a(3'd7, 32'd100, 32'd7, 0, 0, 1'b1, 64'h0000_0002_0000_000E, 1'b0, 33);
      chk("b2b_busy", 64'(ifa.busy), 64'd1);
      drain_a(60);

      // Flush mid-divide, with an ignored start while busy
      issue_a(3'd6, 32'd1000, 32'd7, 0, 0, 1'b0, 64'd0, 1'b0, 0);
      repeat (3) @(negedge clk);
      ifa.op = 3'd0; ifa.operand_1 = 32'd9; ifa.operand_2 = 32'd9; ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      repeat (5) @(negedge clk);
      ifa.flush = 1'b1;
      @(negedge clk);
      ifa.flush = 1'b0;
      chk("flush_busy", 64'(ifa.busy), 64'd0);
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifa.done === 1'b1) nd++;
      end
      chk("flush_no_done", 64'(nd), 64'd0);
      chk("flush_result", ifa.result, 64'h0000_0002_0000_000E);
      chk("flush_dz", 64'(ifa.div_zero), 64'd0);

      // Flush and start together in IDLE: nothing accepted
      ifa.op = 3'd1; ifa.operand_1 = 32'd5; ifa.operand_2 = 32'd5;
      ifa.start = 1'b1; ifa.flush = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0; ifa.flush = 1'b0;
      chk("fs_busy", 64'(ifa.busy), 64'd0);
      nd = 0;
      repeat (4) begin
         @(negedge clk);
         if (ifa.done === 1'b1) nd++;
      end
      chk("fs_no_done", 64'(nd), 64'd0);
      chk("fs_result", ifa.result, 64'h0000_0002_0000_000E);

      // Random operations against the reference model
      for (int i = 0; i < 12; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i % 4 == 0) ? 32'($urandom_range(0, 2)) : $urandom;
         rh  = $urandom;
         rl  = $urandom;
         e64 = model(32, rop, ra, rb, rh, rl, edz);
         run_a(rop, ra, rb, rh, rl, e64, edz,
               (rop[2] & rop[1]) ? (edz ? 1 : 33) : 2);
      end

      // Asynchronous reset in the middle of a divide
      issue_a(3'd6, 32'd555, 32'd3, 0, 0, 1'b1, 64'd0, 1'b0, 33);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_result", ifa.result, 64'd0);
      chk("arst_busy", 64'(ifa.busy), 64'd0);
      chk("arst_done", 64'(ifa.done), 64'd0);
      chk("arst_dz", 64'(ifa.div_zero), 64'd0);
      qa.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_a(3'd1, 32'd3, 32'd4, 0, 0, 64'd12, 1'b0, 2);

      // 16-bit, latency-3 instance
      run_b(3'd6, 32'hFFF9, 32'd2, 64'hFFFF_FFFD, 1'b0, 17);
      run_b(3'd0, 32'hFFFD, 32'd5, 64'hFFFF_FFF1, 1'b0, 3);
      run_b(3'd7, 32'h1234, 32'd0, 64'h1234_FFFF, 1'b1, 1);
      run_b(3'd6, 32'h8000, 32'hFFFF, 64'h0000_8000, 1'b0, 17);
      run_b(3'd7, 32'hFFFF, 32'h10, 64'h000F_0FFF, 1'b0, 17);
      for (int i = 0; i < 4; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         e64 = model(16, rop, ra, rb, 32'd0, 32'd0, edz);
         run_b(rop, ra, rb, e64, edz, (rop[2] & rop[1]) ? (edz ? 1 : 17) : 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
